// File: rtl/i2c_read_sched.sv
// i2c_read_sched: shares one two-byte I2C read engine between two requesters, round-robin, with watchdog.
// Optional macro AUTO_POLL_EN adds a timer that requests a read for requester 0 every POLL_PERIOD cycles.
module i2c_read_sched #(
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned POLL_PERIOD = 50000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  req,
    input  logic [6:0]  addr0,
    input  logic [6:0]  addr1,
    input  logic        busy,
    input  logic [7:0]  data_rd,
    output logic        en,
    output logic [6:0]  slv_addr,
    output logic [1:0]  gnt,
    output logic [15:0] data_out,
    output logic [1:0]  valid,
    output logic [1:0]  err
);
    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StGrant   = 4'd1;
    localparam logic [3:0] StStart   = 4'd2;
    localparam logic [3:0] StWaitMsb = 4'd3;
    localparam logic [3:0] StCapMsb  = 4'd4;
    localparam logic [3:0] StWaitB2  = 4'd5;
    localparam logic [3:0] StHold    = 4'd6;
    localparam logic [3:0] StCapLsb  = 4'd7;
    localparam logic [3:0] StErr     = 4'd8;

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    logic [3:0]  r_state, w_state_d;
    logic [1:0]  r_pend, w_pend_d, w_clr;
    logic        r_last, w_idx, w_grant;
    logic [15:0] r_wd;
    logic        w_wd_hit, w_waiting, w_poll;
    logic [7:0]  r_msb;
    logic [1:0]  r_gnt;
    logic [6:0]  r_addr;
    logic [15:0] r_data;

`ifdef AUTO_POLL_EN
    logic [31:0] r_poll;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_poll <= '0;
        end else if (r_poll == POLL_PERIOD - 1) begin
            r_poll <= '0;
        end else begin
            r_poll <= r_poll + 32'd1;
        end
    end

    assign w_poll = (r_poll == POLL_PERIOD - 1);
`else
    // POLL_PERIOD has no effect without the poll timer
    assign w_poll = 1'b0 & (POLL_PERIOD != 0);
`endif

    // Both pending: alternate away from the last served; otherwise take the one pending
    assign w_idx    = (&r_pend) ? ~r_last : r_pend[1];
    assign w_grant  = (r_state == StIdle) && (|r_pend);
    assign w_clr    = w_grant ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
    assign w_pend_d = (r_pend & ~w_clr) | req | {1'b0, w_poll};

    assign w_wd_hit  = (r_wd == TimeoutCnt);
    assign w_waiting = (r_state == StStart) || (r_state == StWaitMsb) ||
                       (r_state == StWaitB2) || (r_state == StHold);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (|r_pend) w_state_d = StGrant;
            StGrant:   w_state_d = StStart;
            StStart:   if (w_wd_hit) w_state_d = StErr; else if (busy) w_state_d = StWaitMsb;
            StWaitMsb: if (w_wd_hit) w_state_d = StErr; else if (!busy) w_state_d = StCapMsb;
            StCapMsb:  w_state_d = StWaitB2;
            StWaitB2:  if (w_wd_hit) w_state_d = StErr; else if (busy) w_state_d = StHold;
            StHold:    if (w_wd_hit) w_state_d = StErr; else if (!busy) w_state_d = StCapLsb;
            StCapLsb:  w_state_d = StIdle;
            StErr:     w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
            r_pend  <= '0;
            r_last  <= 1'b1;
            r_wd    <= '0;
            r_msb   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_d;
            if (w_state_d != r_state) begin
                r_wd <= '0;
            end else if (w_waiting) begin
                r_wd <= r_wd + 16'd1;
            end
            if (w_grant) begin
                r_gnt  <= w_idx ? 2'b10 : 2'b01;
                r_addr <= w_idx ? addr1 : addr0;
            end else if (r_state == StCapLsb || r_state == StErr) begin
                r_gnt  <= '0;
                r_last <= r_gnt[1];
            end
            // Bytes are taken on the edge that sees busy fall
            if (r_state == StWaitMsb && w_state_d == StCapMsb) begin
                r_msb <= data_rd;
            end
            if (r_state == StHold && w_state_d == StCapLsb) begin
                r_data <= {r_msb, data_rd};
            end
        end
    end

    assign en = (r_state == StStart) || (r_state == StWaitMsb) ||
                (r_state == StCapMsb) || (r_state == StWaitB2);
    assign slv_addr = r_addr;
    assign gnt      = r_gnt;
    assign data_out = r_data;
    assign valid    = (r_state == StCapLsb) ? r_gnt : 2'b00;
    assign err      = (r_state == StErr) ? r_gnt : 2'b00;

endmodule

// File: tb/tb_i2c_read_sched.sv
// tb_i2c_read_sched: directed bench with a transaction-level model of the scheduler and an engine model.
// Define AUTO_POLL_EN to run the auto-poll scenario instead of the directed ones.
module tb_i2c_read_sched;
    localparam int unsigned T    = 1024;
    localparam int unsigned P    = 100;
    localparam int          BLEN = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [6:0]  addr0 = 7'h00;
    logic [6:0]  addr1 = 7'h00;
    logic        busy = 1'b0;
    logic [7:0]  data_rd = 8'h00;
    logic        en;
    logic [6:0]  slv_addr;
    logic [1:0]  gnt;
    logic [15:0] data_out;
    logic [1:0]  valid;
    logic [1:0]  err;

    i2c_read_sched #(.TIMEOUT(T), .POLL_PERIOD(P)) dut (
        .CLK(CLK), .RST(RST), .req(req), .addr0(addr0), .addr1(addr1), .busy(busy),
        .data_rd(data_rd), .en(en), .slv_addr(slv_addr), .gnt(gnt), .data_out(data_out),
        .valid(valid), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit seen_both = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Engine model: one word per transaction from resp_q; stall_n transactions get no busy at all
    logic [15:0] resp_q[$];
    int stall_n = 0;

    task automatic eng_byte(input logic [7:0] b);
        busy = 1'b1;
        for (int k = 0; k < BLEN && !RST; k++) @(negedge CLK);
        busy = 1'b0;
        data_rd = b;
    endtask

    initial begin : engine
        logic [15:0] w;
        forever begin
            @(negedge CLK);
            if (RST) begin
                busy = 1'b0;
            end else if (en) begin
                if (stall_n > 0 || resp_q.size() == 0) begin
                    if (stall_n > 0) stall_n--;
                    while (en && !RST) @(negedge CLK);
                end else begin
                    w = resp_q.pop_front();
                    eng_byte(w[15:8]);
                    for (int k = 0; k < 2 && !RST; k++) @(negedge CLK);
                    if (!RST) eng_byte(w[7:0]);
                end
            end
        end
    end

    // Reference model: pending set, round-robin choice, then one transaction walked phase by phase
    logic [1:0]  m_pend;
    logic        m_last, m_busy;
    logic [7:0]  m_rd, m_msb;
    logic        x_en;
    logic [1:0]  x_gnt, x_valid, x_err;
    logic [15:0] x_data;
    logic [6:0]  x_addr;
`ifdef AUTO_POLL_EN
    int m_cnt;
`endif

    task automatic m_reset();
        m_pend = 2'b00; m_last = 1'b1; m_msb = 8'h00;
        x_en = 1'b0; x_gnt = 2'b00; x_valid = 2'b00; x_err = 2'b00;
        x_data = 16'h0000; x_addr = 7'h00;
`ifdef AUTO_POLL_EN
        m_cnt = 0;
`endif
    endtask

    task automatic m_edge(input logic [1:0] clr, output bit ab);
        @(posedge CLK);
        m_busy = busy;
        m_rd = data_rd;
        if (RST) begin
            m_reset();
            ab = 1'b1;
        end else begin
            ab = 1'b0;
            m_pend = (m_pend & ~clr) | req;
`ifdef AUTO_POLL_EN
            m_cnt++;
            if (m_cnt % P == 0) m_pend[0] = 1'b1;
`endif
        end
    endtask

    // A wait phase ends at the first edge seeing busy==lvl; res 0 done, 1 timed out, 2 reset
    task automatic m_wait(input logic lvl, output int res);
        bit ab;
        res = 1;
        for (int n = 0; n <= int'(T); n++) begin
            m_edge(2'b00, ab);
            if (ab) begin res = 2; return; end
            if (n == int'(T)) begin res = 1; return; end
            if (m_busy == lvl) begin res = 0; return; end
        end
    endtask

    task automatic m_txn();
        bit ab;
        int res;
        logic idx;
        logic [1:0] oh;
        idx = (m_pend == 2'b11) ? ~m_last : m_pend[1];
        oh = idx ? 2'b10 : 2'b01;
        m_edge(oh, ab);
        if (ab) return;
        x_gnt = oh;
        x_addr = idx ? addr1 : addr0;
        m_edge(2'b00, ab);
        if (ab) return;
        x_en = 1'b1;
        m_wait(1'b1, res);
        if (res == 0) begin
            m_wait(1'b0, res);
            if (res == 0) begin
                m_msb = m_rd;
                m_edge(2'b00, ab);
                if (ab) return;
                m_wait(1'b1, res);
                if (res == 0) begin
                    x_en = 1'b0;
                    m_wait(1'b0, res);
                end
            end
        end
        if (res == 2) return;
        x_en = 1'b0;
        if (res == 1) x_err = oh;
        else begin
            x_data = {m_msb, m_rd};
            x_valid = oh;
        end
        m_edge(2'b00, ab);
        if (ab) return;
        x_valid = 2'b00; x_err = 2'b00; x_gnt = 2'b00;
        m_last = idx;
    endtask

    initial begin : model
        bit ab;
        m_reset();
        forever begin
            if (m_pend != 2'b00) m_txn();
            else m_edge(2'b00, ab);
        end
    end

    initial begin : compare
        forever begin
            @(posedge CLK);
            #2;
            chk("en", en, x_en);
            chk("gnt", gnt, x_gnt);
            chk("valid", valid, x_valid);
            chk("err", err, x_err);
            chk("data_out", data_out, x_data);
            if (x_en) chk("slv_addr", slv_addr, x_addr);
            if (gnt == 2'b11) seen_both = 1'b1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse_req(input logic [1:0] r);
        @(negedge CLK);
        req = r;
        @(negedge CLK);
        req = 2'b00;
    endtask

    function automatic bit cond_ok(input int c);
        case (c)
            0:       return valid != 2'b00;
            1:       return en;
            2:       return err != 2'b00;
            default: return !en && gnt != 2'b00;
        endcase
    endfunction

    task automatic wait_cond(input int c, input string nm);
        int k = 0;
        while (!cond_ok(c) && k < 3000) begin
            tick();
            k++;
        end
        chk(nm, 32'(k < 3000), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin : stim
        int t0;
        int nv;
        repeat (3) @(negedge CLK);
        chk("rst_en", en, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_data", data_out, 0);
        chk("rst_addr", slv_addr, 0);
        RST = 1'b0;
        addr0 = 7'h48;
        addr1 = 7'h21;
`ifdef AUTO_POLL_EN
        repeat (3) resp_q.push_back(16'hA55A);
        nv = 0;
        repeat (350) begin
            tick();
            if (valid[0]) nv++;
        end
        chk("poll_valid_count", nv, 3);
        chk("poll_data", data_out, 16'hA55A);
`else
        // Contention straight after reset: 0 first, then 1
        resp_q.push_back(16'h1122);
        resp_q.push_back(16'h3344);
        pulse_req(2'b11);
        wait_cond(0, "wait_cont_a");
        chk("cont_first_valid", valid, 2'b01);
        chk("cont_first_data", data_out, 16'h1122);
        tick();
        wait_cond(0, "wait_cont_b");
        chk("cont_second_valid", valid, 2'b10);
        chk("cont_second_data", data_out, 16'h3344);
        chk("gnt_never_both", seen_both, 0);
        repeat (2) tick();

        // Single read: latency req@0 -> gnt@2 -> en@3
        resp_q.push_back(16'h1A80);
        @(negedge CLK); req = 2'b01;
        @(negedge CLK); req = 2'b00;
        chk("lat_c1_gnt", gnt, 2'b00);
        @(negedge CLK);
        chk("lat_c2_gnt", gnt, 2'b01);
        chk("lat_c2_en", en, 0);
        @(negedge CLK);
        chk("lat_c3_en", en, 1);
        chk("lat_c3_addr", slv_addr, 7'h48);
        wait_cond(0, "wait_single");
        chk("single_valid", valid, 2'b01);
        chk("single_data", data_out, 16'h1A80);
        tick();
        chk("single_valid_len", valid, 2'b00);

        // Timeout on requester 0, requester 1 pending behind it
        stall_n = 1;
        resp_q.push_back(16'h5AA5);
        pulse_req(2'b01);
        wait_cond(1, "wait_to_en");
        t0 = cyc;
        pulse_req(2'b10);
        wait_cond(2, "wait_err");
        chk("timeout_latency", cyc - t0, T + 1);
        chk("timeout_err", err, 2'b01);
        chk("timeout_en", en, 0);
        chk("timeout_data_kept", data_out, 16'h1A80);
        tick();
        chk("err_len", err, 2'b00);
        wait_cond(0, "wait_after_err");
        chk("after_err_valid", valid, 2'b10);
        chk("after_err_data", data_out, 16'h5AA5);

        // Requests while in service, duplicates merge into one extra read
        resp_q.push_back(16'h0102);
        resp_q.push_back(16'h0304);
        pulse_req(2'b01);
        wait_cond(1, "wait_svc_en");
        repeat (2) tick();
        pulse_req(2'b01);
        pulse_req(2'b01);
        nv = 0;
        repeat (80) begin
            tick();
            if (valid[0]) nv++;
        end
        chk("svc_valid_count", nv, 2);
        chk("svc_last_data", data_out, 16'h0304);

        // Reset while in HOLD
        addr1 = 7'h33;
        resp_q.push_back(16'hEEFF);
        pulse_req(2'b10);
        wait_cond(1, "wait_rst_en");
        wait_cond(3, "wait_hold");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_hold_en", en, 0);
        chk("rst_hold_gnt", gnt, 0);
        chk("rst_hold_data", data_out, 0);
        chk("rst_hold_valid", valid, 0);
        chk("rst_hold_err", err, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        resp_q.push_back(16'hC33C);
        pulse_req(2'b01);
        wait_cond(0, "wait_post_rst");
        chk("post_rst_valid", valid, 2'b01);
        chk("post_rst_data", data_out, 16'hC33C);
`endif
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
